// File: rtl/rom_tone_player.sv
// rom_tone_player
// Walks the note ROM from address 0 to LAST_ADDR and plays each word as a
// square wave. Each ROM word is a half-period in clocks, and 0 means a rest.
// Every note takes NOTE_LEN+2 clocks: one FETCH, one LOAD, then NOTE_LEN of PLAY.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   level; begins playback from address 0 when idle
//   stop     in   aborts playback back to idle (beats a coincident note end)
//   loop     in   sampled at the end of the last note; 1 = wrap to address 0
//   rom_data in   registered ROM output, valid one clock after addr changes
//   addr     out  ROM address (registered)
//   tone     out  square-wave audio (registered)
//   busy     out  high whenever not idle
//   done     out  one-cycle pulse when a non-looping sequence finishes
module rom_tone_player #(
    parameter int unsigned LAST_ADDR = 15,
    parameter int unsigned NOTE_LEN  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    input  logic [15:0] rom_data,
    output logic [3:0]  addr,
    output logic        tone,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

    localparam logic [3:0]  LAST_A   = LAST_ADDR[3:0];
    localparam logic [31:0] NOTE_END = NOTE_LEN - 1;

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic        tone_q, tone_d;
    logic        done_q, done_d;
    logic [15:0] div_q, div_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [31:0] note_cnt_q, note_cnt_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tone_d     = tone_q;
        done_d     = 1'b0;
        div_d      = div_q;
        half_cnt_d = half_cnt_q;
        note_cnt_d = note_cnt_q;

        case (state_q)
            S_IDLE: begin
                tone_d = 1'b0;
                if (start && !stop) begin
                    state_d = S_FETCH;
                    addr_d  = 4'd0;
                end
            end
            // addr has been stable for this cycle, so the ROM captures it at
            // the closing edge. LOAD then sees the matching word.
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                div_d      = rom_data;
                half_cnt_d = 16'd0;
                note_cnt_d = 32'd0;
                tone_d     = 1'b0;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                note_cnt_d = note_cnt_q + 32'd1;
                if (div_q != 16'd0) begin
                    // A toggle every div clocks gives a half-period of exactly div.
                    if (half_cnt_q == div_q - 16'd1) begin
                        tone_d     = ~tone_q;
                        half_cnt_d = 16'd0;
                    end else begin
                        half_cnt_d = half_cnt_q + 16'd1;
                    end
                end else begin
                    tone_d = 1'b0;
                end
                if (note_cnt_q == NOTE_END) begin
                    if (addr_q != LAST_A) begin
                        addr_d  = addr_q + 4'd1;
                        state_d = S_FETCH;
                    end else if (loop) begin
                        addr_d  = 4'd0;
                        state_d = S_FETCH;
                    end else begin
                        addr_d  = 4'd0;
                        tone_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // stop overrides everything above, including a final note end.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            addr_d  = 4'd0;
            tone_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 4'd0;
            tone_q     <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= 16'd0;
            half_cnt_q <= 16'd0;
            note_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tone_q     <= tone_d;
            done_q     <= done_d;
            div_q      <= div_d;
            half_cnt_q <= half_cnt_d;
            note_cnt_q <= note_cnt_d;
        end
    end

    assign addr = addr_q;
    assign tone = tone_q;
    assign done = done_q;
    // done is only raised while entering IDLE, so busy and done never overlap.
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_tone_player.sv
// Directed bench for rom_tone_player (NOTE_LEN=8, LAST_ADDR=2).
// Cycle k means the state just after the k-th rising edge, where edge 1 is
// the edge that samples start. The expected tables below are written by hand.
module tb_rom_tone_player;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop;
    logic [15:0] rom_data;
    logic [3:0]  addr;
    logic        tone, busy, done;

    logic [15:0] rom [16];
    int          cyc;
    int          n_chk  = 0;
    int          n_fail = 0;

    // Expected tone for k = 1..32 with ROM = {2, 3, 0}.
    logic [0:31] exp_tone_v = 32'b00001100110000011100000000000000;

    rom_tone_player #(.LAST_ADDR(2), .NOTE_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .rom_data(rom_data), .addr(addr), .tone(tone), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // The ROM is registered, as in the real note ROM.
    always @(posedge clk) rom_data <= rom[addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic go();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    function automatic int exp_addr(input int k);
        if (k <= 10) return 0;
        if (k <= 20) return 1;
        if (k <= 30) return 2;
        return 0;
    endfunction

    task automatic chk_tbl();
        chk("seq_addr", int'(addr), exp_addr(cyc));
        chk("seq_tone", int'(tone), int'(exp_tone_v[cyc-1]));
        chk("seq_busy", int'(busy), (cyc <= 30) ? 1 : 0);
        chk("seq_done", int'(done), (cyc == 31) ? 1 : 0);
    endtask

    task automatic play_check(input int upto);
        chk_tbl();
        while (cyc < upto) begin
            tick();
            chk_tbl();
        end
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; cyc = 0;
        for (int i = 0; i < 16; i++) rom[i] = 16'hBEEF;
        rom[0] = 16'h0002; rom[1] = 16'h0003; rom[2] = 16'h0000;

        // Reset state
        #12;
        chk("rst_addr", int'(addr), 0);
        chk("rst_tone", int'(tone), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // start and stop together in IDLE do nothing
        start = 1'b1; stop = 1'b1;
        tick();
        chk("startstop_busy", int'(busy), 0);
        start = 1'b0; stop = 1'b0;
        tick();

        // Basic sequence, full cycle table including done
        go();
        play_check(32);
        tick();

        // Loop: wiggling loop mid-sequence is ignored, only the last note end counts
        loop = 1'b1;
        go();
        run_to(15); loop = 1'b0;
        run_to(25); loop = 1'b1;
        run_to(31);
        chk("loop_wrap_addr", int'(addr), 0);
        chk("loop_wrap_busy", int'(busy), 1);
        chk("loop_wrap_done", int'(done), 0);
        run_to(41);
        chk("loop_addr1", int'(addr), 1);
        run_to(45); loop = 1'b0;
        run_to(51);
        chk("loop_addr2", int'(addr), 2);
        run_to(60);
        chk("loop_end_busy_pre", int'(busy), 1);
        chk("loop_end_done_pre", int'(done), 0);
        run_to(61);
        chk("loop_end_done", int'(done), 1);
        chk("loop_end_busy", int'(busy), 0);
        chk("loop_end_addr", int'(addr), 0);
        run_to(62);
        chk("loop_done_pulse", int'(done), 0);

        // start while busy is ignored, then stop mid-note 1
        go();
        run_to(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_addr", int'(addr), 0);
        chk("busy_start_tone", int'(tone), 1);
        run_to(11);
        chk("no_restart_addr", int'(addr), 1);
        run_to(17);
        chk("pre_stop_tone", int'(tone), 1);
        chk("pre_stop_addr", int'(addr), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_tone", int'(tone), 0);
        chk("stop_addr", int'(addr), 0);
        chk("stop_done", int'(done), 0);
        run_to(22);
        chk("stop_stays_idle", int'(busy), 0);

        // Asynchronous reset while tone is high
        go();
        run_to(16);
        chk("pre_rst_tone", int'(tone), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_tone", int'(tone), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_addr", int'(addr), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_idle", int'(busy), 0);
        go();
        play_check(12);
        abort();

        // stop coincident with the final note end: no done
        go();
        run_to(30);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("coinc_busy", int'(busy), 0);
        chk("coinc_done", int'(done), 0);
        chk("coinc_addr", int'(addr), 0);
        chk("coinc_tone", int'(tone), 0);
        tick();
        chk("coinc_done_after", int'(done), 0);

        // Divider 1 toggles every clock
        rom[0] = 16'h0001;
        go();
        run_to(3);
        chk("div1_entry_tone", int'(tone), 0);
        for (int k = 4; k <= 10; k++) begin
            tick();
            chk("div1_tone", int'(tone), (k % 2 == 0) ? 1 : 0);
        end
        abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
